// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: round-robin arbiter sharing one cache port among NUM_CORES cores
module cache_bus_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int TIMEOUT   = 64,
    parameter int OW        = $clog2(NUM_CORES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CORES-1:0]    req,
    input  logic [NUM_CORES-1:0]    rw_in,
    input  logic [12*NUM_CORES-1:0] addr_in,
    input  logic [NUM_CORES-1:0]    done,
    output logic [NUM_CORES-1:0]    gnt,
    output logic                    cache_valid,
    output logic                    cache_rw,
    output logic [11:0]             cache_addr,
    output logic [OW-1:0]           owner,
    output logic                    busy,
    output logic                    timeout_err
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    state_t        state;
    logic [OW-1:0] ptr;
    logic [OW-1:0] win;
    logic [OW-1:0] hi;
    logic [OW-1:0] lo;
    logic          hi_ok;
    logic          sel_rw;
    logic [11:0]   sel_addr;
    logic [TW-1:0] timer;
    logic          release_now;

    // winner is the lowest requester at or above ptr, else the lowest requester overall (wrap)
    always_comb begin
        hi = '0;
        lo = '0;
        hi_ok = 1'b0;
        sel_rw = 1'b0;
        sel_addr = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo = OW'(i);
                if (i >= int'(ptr)) begin
                    hi = OW'(i);
                    hi_ok = 1'b1;
                end
            end
        end
        win = hi_ok ? hi : lo;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (OW'(i) == win) begin
                sel_rw = rw_in[i];
                sel_addr = addr_in[12*i +: 12];
            end
        end
    end

    assign release_now = done[owner] || (timer == TW'(TIMEOUT - 1));

    // arbitration FSM with registered outputs; done from the owner beats a simultaneous timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            timer       <= '0;
            gnt         <= '0;
            cache_valid <= 1'b0;
            cache_rw    <= 1'b0;
            cache_addr  <= '0;
            owner       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state       <= BUSY;
                        gnt         <= NUM_CORES'(1) << win;
                        owner       <= win;
                        cache_valid <= 1'b1;
                        cache_rw    <= sel_rw;
                        cache_addr  <= sel_addr;
                        busy        <= 1'b1;
                        timer       <= '0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state       <= RELEASE;
                        gnt         <= '0;
                        owner       <= '0;
                        cache_valid <= 1'b0;
                        cache_rw    <= 1'b0;
                        cache_addr  <= '0;
                        ptr         <= (owner == OW'(NUM_CORES - 1)) ? '0 : owner + 1'b1;
                        timeout_err <= !done[owner];
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
